// File: rtl/im_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the instruction memory
// address, captures {pc, word} into a small prefetch queue and hands the queue
// head to decode over a valid/ready handshake. Supports branch redirect (flush)
// and a level-sensitive fetch halt.
module im_fetch_ctrl #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [15:0]                im_addr,
    input  logic [31:0]                im_data,
    output logic [31:0]                instr_out,
    output logic [15:0]                instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       redirect,
    input  logic [15:0]                redirect_addr,
    input  logic                       fetch_halt,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Fetch PC, queue pointers and occupancy
    logic [15:0]     pc_q, pc_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW-1:0] wr_q, wr_d;
    logic [CntW-1:0] count_q, count_d;

    // Queue storage: {pc, instruction word}
    logic [47:0]     entry_q [DEPTH];
    logic [47:0]     head;

    logic            pop;
    logic            push;
    logic            not_full;

    // Handshake and enqueue qualification
    always_comb begin
        not_full = (count_q < CntW'(DEPTH));
        pop      = (count_q != '0) & instr_ready;
        // A full queue may still accept a word when the head leaves this cycle.
        push     = ~redirect & ~fetch_halt & (not_full | pop);
    end

    // Next-state for PC, pointers and occupancy; redirect flushes everything
    always_comb begin
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = redirect_addr;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + 16'd1;
                wr_d = wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Queue storage write; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            entry_q[wr_q] <= {pc_q, im_data};
        end
    end

    // Head presentation; zeroed while the queue is empty
    always_comb begin
        head        = entry_q[rd_q];
        instr_valid = (count_q != '0);
        instr_pc    = instr_valid ? head[47:32] : 16'h0000;
        instr_out   = instr_valid ? head[31:0]  : 32'h0000_0000;
        im_addr     = pc_q;
        q_count     = count_q;
    end

endmodule
